data_mem_responder: RTL
=======================

# data_mem_responder

Memory-side responder for the reference CPU's data-bus request (addr, size, strobe, data). It accepts one request at a time and services it against an internal word-addressed RAM. It returns a handshake and read data after a fixed latency, and flags requests whose strobe, size and alignment are inconsistent. It serves as the data memory for refcpu simulation and as the bench model for the store/load request generator.

## Interface
- DEPTH, 1024, number of 32-bit words in the RAM; power of two.
- LATENCY, 1, cycles from acceptance to `resp_data_ok`; must be ≥1.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present; requester holds it and all req_* fields stable until `resp_addr_ok`.
- req_addr  in  32  byte address; word index = `req_addr[log2(DEPTH)+1:2]`, upper bits ignored, so the index wraps modulo DEPTH.
- req_size  in  3  MSIZE1=3'b000, MSIZE2=3'b001, MSIZE4=3'b010; all other encodings are illegal.
- req_strobe  in  4  byte-lane write enables; 0 means read.
- req_data  in  32  write data, already replicated on lanes.
- resp_addr_ok  out  1  request accepted this cycle (combinational).
- resp_data_ok  out  1  response valid; one-cycle pulse.
- resp_data  out  32  read word; 0 for writes.
- protocol_err  out  1  sticky error flag.

## Operation
- States:
  - IDLE: no outstanding request.
  - BUSY: request accepted; counter running.
- `resp_addr_ok = req_valid & (state==IDLE | resp_data_ok)`. A new request may therefore be accepted in the same cycle the previous response pulses.
- On acceptance (rising edge closing the accept cycle):
  - Enter BUSY with counter = LATENCY-1.
  - Write: if strobe≠0, the RAM word at the index is updated on lanes `strobe & legal`. Lanes outside that mask keep their old value.
  - Read: if strobe=0, the word is captured into the response register at acceptance, so later writes do not affect the returned data.
- Legal lanes:
  - MSIZE1: `4'b0001 << addr[1:0]`.
  - MSIZE2: 4'b0011 if addr[1]=0, else 4'b1100.
  - MSIZE4: 4'b1111.
  - Illegal size: 4'b0000.
- Protocol error conditions; any one sets `protocol_err` on acceptance and it stays set until reset:
  - Any bit of `strobe & ~legal` is set.
  - MSIZE2 with addr[0]=1.
  - MSIZE4 with addr[1:0]≠0.
  - Illegal size encoding.
- An erroneous request still completes normally: the masked write is applied and a response is returned.
- BUSY:
  - Counter decrements each cycle.
  - `resp_data_ok` = 1 when counter = 0, then return to IDLE, or stay BUSY if a new request is accepted in that cycle.
- While `resp_data_ok` = 0, `resp_data` holds 0.
- The RAM array is not reset. The bench initialises contents through writes.

## Timing
- Reset values:
  - `resp_data_ok` = 0, `resp_data` = 0, `protocol_err` = 0, state IDLE, counter 0.
  - `resp_addr_ok` = 0 while reset is asserted.
- Acceptance in cycle T gives `resp_data_ok` = 1 in cycle T+LATENCY, for exactly one cycle.
- Throughput is one request per LATENCY cycles. With LATENCY=1, back-to-back requests are accepted every cycle.
- A read in the cycle immediately after a write to the same word returns the written lanes. Write-then-read ordering is preserved.
- Reset asserted mid-transaction:
  - The outstanding request is discarded and no `resp_data_ok` is produced.
  - A write already committed at acceptance remains in RAM.
- A request held with `req_valid` while BUSY (and not in the `data_ok` cycle) sees `resp_addr_ok` = 0. It is accepted the first cycle the condition holds.

## Test plan
- Write word then read back (LATENCY=1):
  - SW addr 0x10, strobe 1111, data 0xDEADBEEF → `addr_ok` in T, `data_ok` in T+1 with `resp_data` = 0.
  - Read 0x10 → `resp_data` = 0xDEADBEEF, `protocol_err` = 0.
- Byte and halfword lanes:
  - Start with word 0x11223344 at 0x20.
  - SB addr 0x22, strobe 0100, data 0xAAAAAAAA → read returns 0x11AA3344.
  - SH addr 0x20, strobe 0011, data 0x55665566 → read returns 0x11AA5566.
- Latency/throughput with LATENCY=3:
  - Four reads held back-to-back → `addr_ok` at cycles 0, 3, 6, 9.
  - `data_ok` at cycles 3, 6, 9, 12, each one cycle wide.
- Protocol errors:
  - SH addr 0x31 → `protocol_err` rises after acceptance and the response still arrives.
  - Separately, SB addr 0x40 with strobe 0011 → only lane 0 written, `protocol_err` = 1 until reset.
- Wrap-around (DEPTH=1024): write 0x12345678 to 0x1000 → read of 0x0000 returns 0x12345678.
- Reset mid-op (LATENCY=4): assert reset 2 cycles after accepting a read → no `data_ok`, all outputs 0. The next request after deassertion completes normally.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-bus memory responder: one outstanding request, fixed-latency
// handshake, byte-lane masked writes and a sticky protocol error flag.
module data_mem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_size,
   input  logic [3:0]  req_strobe,
   input  logic [31:0] req_data,
   output logic        resp_addr_ok,
   output logic        resp_data_ok,
   output logic [31:0] resp_data,
   output logic        protocol_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   rd_q;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] idx;
   logic [3:0]    legal;
   logic [3:0]    mask;
   logic          err;
   logic          accept;
   logic          unused_addr;

   assign idx         = req_addr[AW+1:2];
   assign unused_addr = ^{req_addr[31:AW+2]};

   always_comb begin
      legal = 4'b0000;
      case (req_size)
         3'b000:  legal = 4'b0001 << req_addr[1:0];
         3'b001:  legal = req_addr[1] ? 4'b1100 : 4'b0011;
         3'b010:  legal = 4'b1111;
         default: legal = 4'b0000;
      endcase
   end

   assign mask = req_strobe & legal;

   assign err = (|(req_strobe & ~legal))
              | ((req_size == 3'b001) & req_addr[0])
              | ((req_size == 3'b010) & (|req_addr[1:0]))
              | (req_size > 3'b010);

   assign resp_data_ok = (state == BUSY) && (cnt == '0);
   assign resp_addr_ok = req_valid & ~reset
                       & ((state == IDLE) | resp_data_ok);
   assign accept       = resp_addr_ok;
   assign resp_data    = resp_data_ok ? rd_q : 32'h0;

   // Read data is sampled at acceptance so later writes cannot leak in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         rd_q         <= 32'h0;
         protocol_err <= 1'b0;
      end else begin
         if (accept) begin
            state <= BUSY;
            cnt   <= CW'(LATENCY - 1);
            rd_q  <= (req_strobe == 4'b0000) ? mem[idx] : 32'h0;
            if (err)
               protocol_err <= 1'b1;
         end else if (state == BUSY) begin
            if (cnt == '0)
               state <= IDLE;
            else
               cnt <= cnt - 1'b1;
         end
      end
   end

   // RAM contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int b = 0; b < 4; b++) begin
            if (mask[b])
               mem[idx][8*b +: 8] <= req_data[8*b +: 8];
         end
      end
   end

endmodule
